// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of one synchronous RAM port between two masters
// Ports: clk, reset (sync, active-high)
//        m0_*/m1_*: addr/wdata/re/we requests in; gnt, rvalid, err out
//        rdata: read data shared by both masters, qualified by mX_rvalid
//        ram_*: RAM port; ram_dout is valid one cycle after ram_re
module ram_arbiter #(
   parameter int AW    = 11,
   parameter int BURST = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [29:0]   m0_addr,
   input  logic [31:0]   m0_wdata,
   input  logic          m0_re,
   input  logic [3:0]    m0_we,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic          m0_err,
   input  logic [29:0]   m1_addr,
   input  logic [31:0]   m1_wdata,
   input  logic          m1_re,
   input  logic [3:0]    m1_we,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic          m1_err,
   output logic [31:0]   rdata,
   output logic [AW-1:0] ram_addr,
   output logic [31:0]   ram_din,
   output logic          ram_re,
   output logic [3:0]    ram_we,
   input  logic [31:0]   ram_dout
);
   localparam logic [3:0] BURST_C = 4'(BURST);
   logic owner_q, owner_d, prev_q, prev_d, rpend_q, rpend_d, rsel_q, rsel_d;
   logic epend_q, epend_d, zero_q, zero_d;
   logic [3:0] cnt_q, cnt_d;
   logic req0, req1, any, win, rd, oor;
   logic [29:0] w_addr;
   logic [3:0] w_we;
   always_comb begin
      req0 = m0_re | (|m0_we);
      req1 = m1_re | (|m1_we);
      any = (req0 | req1) & ~reset;
      // on a tie the owner keeps the port only while its unbroken streak is below BURST
      win = (req0 & req1) ? ((prev_q && cnt_q < BURST_C) ? owner_q : ~owner_q) : req1;
      w_addr = win ? m1_addr : m0_addr;
      w_we = win ? m1_we : m0_we;
      rd = ~(|w_we) & (win ? m1_re : m0_re);
      oor = |(w_addr >> AW);
      m0_gnt = any & ~win;
      m1_gnt = any & win;
      ram_addr = w_addr[AW-1:0];
      ram_din = win ? m1_wdata : m0_wdata;
      ram_re = any & ~oor & rd;
      ram_we = (any & ~oor) ? w_we : 4'b0;
      m0_rvalid = rpend_q & ~rsel_q & ~reset;
      m1_rvalid = rpend_q & rsel_q & ~reset;
      m0_err = epend_q & ~rsel_q & ~reset;
      m1_err = epend_q & rsel_q & ~reset;
      // an out-of-range read still answers, but with zero instead of RAM data
      rdata = zero_q ? 32'b0 : ram_dout;
      owner_d = any ? win : owner_q;
      cnt_d = !any ? cnt_q : (prev_q && win == owner_q) ? ((cnt_q == 4'hf) ? cnt_q : cnt_q + 4'd1) : 4'd1;
      prev_d = any;
      rpend_d = any & rd;
      epend_d = any & oor;
      rsel_d = win;
      zero_d = oor;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q <= 1'b1;
         cnt_q <= 4'd0;
         prev_q <= 1'b0;
         rpend_q <= 1'b0;
         epend_q <= 1'b0;
         rsel_q <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         owner_q <= owner_d;
         cnt_q <= cnt_d;
         prev_q <= prev_d;
         rpend_q <= rpend_d;
         epend_q <= epend_d;
         rsel_q <= rsel_d;
         zero_q <= zero_d;
      end
   end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter with directed and random traffic
module tb_ram_arbiter;
   localparam int AW = 11;
   localparam int BURST = 4;
   logic clk = 1'b0, reset;
   logic [29:0] m0_addr, m1_addr;
   logic [31:0] m0_wdata, m1_wdata, rdata, ram_din, ram_dout;
   logic m0_re, m1_re, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, ram_re;
   logic [3:0] m0_we, m1_we, ram_we;
   logic [AW-1:0] ram_addr;
   ram_arbiter #(.AW(AW), .BURST(BURST)) dut (
      .clk(clk), .reset(reset),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_re(m0_re), .m0_we(m0_we),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_err(m0_err),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_re(m1_re), .m1_we(m1_we),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_err(m1_err),
      .rdata(rdata), .ram_addr(ram_addr), .ram_din(ram_din), .ram_re(ram_re),
      .ram_we(ram_we), .ram_dout(ram_dout)
   );
   always #5 clk = ~clk;
   function automatic logic [31:0] bmask(input logic [3:0] we);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{we[b]}};
      return m;
   endfunction
   logic [31:0] mem [0:2**AW-1];
   logic [31:0] ref_mem [0:2**AW-1];
   always @(posedge clk) begin
      if (|ram_we) mem[ram_addr] <= (mem[ram_addr] & ~bmask(ram_we)) | (ram_din & bmask(ram_we));
      if (ram_re) ram_dout <= mem[ram_addr];
   end
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   int checks = 0, errors = 0;
   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", n, cyc, act, req);
      end
   endtask
   typedef struct { logic v; logic re; logic [3:0] we; logic [29:0] addr; logic [31:0] wd; } req_t;
   typedef struct { int due; bit m; bit rv; bit er; logic [31:0] d; } exp_t;
   req_t p [2];
   exp_t q[$];
   bit m_last = 1'b1, m_busy = 1'b0;
   int m_streak = 0, last_win;
   task automatic set_req(input int m, input bit re, input logic [3:0] we, input logic [29:0] a, input logic [31:0] wd);
      p[m] = '{1'b1, re, we, a, wd};
   endtask
   task automatic tick(input bit r);
      bit r0, r1, w, g, oor, rd;
      logic [29:0] a;
      logic [AW-1:0] ia;
      reset = r;
      m0_re = p[0].v & p[0].re;
      m0_we = p[0].v ? p[0].we : 4'b0;
      m0_addr = p[0].v ? p[0].addr : 30'd0;
      m0_wdata = p[0].v ? p[0].wd : 32'd0;
      m1_re = p[1].v & p[1].re;
      m1_we = p[1].v ? p[1].we : 4'b0;
      m1_addr = p[1].v ? p[1].addr : 30'd0;
      m1_wdata = p[1].v ? p[1].wd : 32'd0;
      @(negedge clk);
      r0 = p[0].v;
      r1 = p[1].v;
      g = !r && (r0 || r1);
      w = (r0 && r1) ? ((m_busy && m_streak < BURST) ? m_last : !m_last) : r1;
      last_win = g ? int'(w) : -1;
      chk("gnt", {m0_gnt, m1_gnt}, {g && !w, g && w});
      a = p[w].addr;
      ia = a[AW-1:0];
      oor = (a >> AW) != 0;
      rd = p[w].we == 4'b0;
      chk("ram_en", {ram_re, ram_we}, {g && !oor && rd, (g && !oor) ? p[w].we : 4'b0});
      if (g && !oor) chk("ram_bus", {ram_addr, rd ? 32'b0 : ram_din}, {ia, rd ? 32'b0 : p[w].wd});
      if (g) begin
         if (rd || oor) q.push_back('{cyc + 1, w, rd, oor, (rd && !oor) ? ref_mem[ia] : 32'b0});
         if (!rd && !oor) ref_mem[ia] = (ref_mem[ia] & ~bmask(p[w].we)) | (p[w].wd & bmask(p[w].we));
         if (m_busy && w == m_last) m_streak = (m_streak < 15) ? m_streak + 1 : 15;
         else begin
            m_last = w;
            m_streak = 1;
         end
         p[w].v = 1'b0;
      end
      m_busy = g;
      if (r) begin
         m_last = 1'b1;
         m_streak = 0;
         m_busy = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask
   always @(negedge clk) begin
      exp_t e;
      logic [3:0] ev;
      logic [31:0] ed;
      ev = 4'b0;
      ed = 32'b0;
      while (q.size() != 0 && (q[0].due < cyc || (reset && q[0].due == cyc))) void'(q.pop_front());
      if (!reset && q.size() != 0 && q[0].due == cyc) begin
         e = q.pop_front();
         ev = {e.rv && !e.m, e.rv && e.m, e.er && !e.m, e.er && e.m};
         ed = e.d;
      end
      chk("resp", {m0_rvalid, m1_rvalid, m0_err, m1_err}, ev);
      if (ev[3] | ev[2]) chk("rdata", rdata, ed);
   end
   initial begin
      for (int i = 0; i < 2**AW; i++) begin
         mem[i] = (i * 32'h01010101) ^ 32'hA5A50000;
         ref_mem[i] = (i * 32'h01010101) ^ 32'hA5A50000;
      end
      mem[5] = 32'hDEADBEEF;
      ref_mem[5] = 32'hDEADBEEF;
      p[0].v = 1'b0;
      p[1].v = 1'b0;
      tick(1);
      tick(1);
      set_req(0, 1, 4'b0, 30'd5, 0);
      tick(0);
      chk("rd5_gnt", last_win, 0);
      tick(0);
      tick(1);
      for (int k = 0; k < 16; k++) begin
         set_req(0, 1, 4'b0, 30'd9, 0);
         set_req(1, 1, 4'b0, 30'd10, 0);
         tick(0);
         chk("burst_seq", last_win, (k / 4) % 2);
      end
      p[0].v = 1'b0;
      p[1].v = 1'b0;
      tick(0);
      set_req(1, 0, 4'b0011, 30'd7, 32'h12345678);
      tick(0);
      set_req(0, 1, 4'b0, 30'd7, 0);
      tick(0);
      tick(0);
      set_req(0, 1, 4'b0, 30'h800, 0);
      tick(0);
      tick(0);
      tick(1);
      set_req(0, 1, 4'b0, 30'd1, 0);
      tick(0);
      tick(0);
      set_req(1, 1, 4'b0, 30'd2, 0);
      tick(0);
      tick(0);
      set_req(0, 1, 4'b0, 30'd3, 0);
      set_req(1, 1, 4'b0, 30'd4, 0);
      tick(0);
      chk("idle_tie", last_win, 0);
      tick(0);
      tick(0);
      set_req(1, 1, 4'b0, 30'd6, 0);
      tick(0);
      set_req(0, 1, 4'b0, 30'd3, 0);
      tick(0);
      tick(1);
      set_req(0, 1, 4'b0, 30'd3, 0);
      set_req(1, 1, 4'b0, 30'd4, 0);
      tick(0);
      chk("reset_tie", last_win, 0);
      tick(0);
      tick(0);
      for (int c = 0; c < 600; c++) begin
         for (int m = 0; m < 2; m++)
            if (!p[m].v && $urandom_range(0, 2) != 0) begin
               logic [3:0] we;
               logic [29:0] a;
               we = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'b0;
               a = ($urandom_range(0, 7) == 0) ? ((30'($urandom_range(1, 255)) << AW) | 30'($urandom_range(0, 31))) : 30'($urandom_range(0, 31));
               set_req(m, (we == 4'b0) ? 1'b1 : 1'($urandom_range(0, 1)), we, a, $urandom);
            end
         tick($urandom_range(0, 63) == 0);
      end
      p[0].v = 1'b0;
      p[1].v = 1'b0;
      tick(0);
      tick(0);
      tick(0);
      chk("drain", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
